uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/uart_tx_fifo.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg : shared parity codes, TX state encoding and timing helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo : single-clock first-word-first FIFO with occupancy count
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             w_push, w_pop;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign rdata  = mem_q[rd_ptr_q];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (w_push && !w_pop)      count_d = count_q + 1'b1;
    else if (!w_push && w_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo : FIFO-buffered UART transmitter, frames sent back-to-back.
// Optional line-break input enabled by defining UART_TX_BREAK_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic                              break_req,
`endif
  input  logic [DATA_BITS-1:0]              s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CPB    = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BAUD_W = $clog2(CPB);
  localparam int BIT_W  = $clog2(frame_bits(DATA_BITS, PARITY, STOP_BITS));
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  generate
    if (CPB < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("uart_tx_fifo: illegal parameter value");
    end
  endgenerate

  tx_state_e            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 brk_q, brk_d;

  logic                 w_push, w_pop, w_full, w_empty, w_baud_end, w_brk_req, w_par_bit;
  logic [DATA_BITS-1:0] w_head;
  logic [CNT_W-1:0]     w_cnt_next;

`ifdef UART_TX_BREAK_EN
  assign w_brk_req = break_req;
`else
  assign w_brk_req = 1'b0;
`endif

  assign s_ready    = !w_full;
  assign w_push     = s_valid && !w_full;
  assign w_baud_end = (baud_q == BAUD_W'(CPB - 1));
  assign w_par_bit  = (PARITY == PAR_EVEN) ? par_q : ~par_q;
  assign w_cnt_next = fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign tx         = tx_q;
  assign busy       = busy_q;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (s_data),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    brk_d   = brk_q;
    w_pop   = 1'b0;
    if (state_q != ST_IDLE) baud_d = w_baud_end ? '0 : baud_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (w_brk_req) begin
          tx_d  = 1'b0;
          brk_d = 1'b1;
        end else if (brk_q) begin
          // One full bit period of mark after a break before popping again.
          if (w_baud_end) brk_d = 1'b0;
          else            baud_d = baud_q + 1'b1;
        end else if (!w_empty) begin
          w_pop   = 1'b1;
          shift_d = w_head;
          par_d   = ^w_head;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (w_baud_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (w_baud_end) begin
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = w_par_bit;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (w_baud_end) begin
          state_d = ST_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_baud_end) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (!w_empty && !w_brk_req) begin
              w_pop   = 1'b1;
              shift_d = w_head;
              par_d   = ^w_head;
              state_d = ST_START;
              tx_d    = 1'b0;
            end else begin
              state_d = ST_IDLE;
              tx_d    = !w_brk_req;
              brk_d   = w_brk_req;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || (w_cnt_next != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      brk_q   <= brk_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo : scoreboard bench for uart_tx_fifo (four configurations)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_fifo;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] s_valid, s_ready_w, tx_w, busy_w;
  logic [8:0] s_data [4];
  logic [2:0] cnt0;
  logic [4:0] cnt1, cnt2, cnt3;
`ifdef UART_TX_BREAK_EN
  logic       brk;
`endif

  logic [8:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // 0: 8N1 depth 4   1: 8E1   2: 8O1   3: 7N2
  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_n81 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .break_req(brk),
`endif
    .s_data(s_data[0][7:0]), .s_valid(s_valid[0]), .s_ready(s_ready_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt0));

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_even (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .break_req(1'b0),
`endif
    .s_data(s_data[1][7:0]), .s_valid(s_valid[1]), .s_ready(s_ready_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt1));

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_odd (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .break_req(1'b0),
`endif
    .s_data(s_data[2][7:0]), .s_valid(s_valid[2]), .s_ready(s_ready_w[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt2));

  uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(0),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) u_7n2 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .break_req(1'b0),
`endif
    .s_data(s_data[3][6:0]), .s_valid(s_valid[3]), .s_ready(s_ready_w[3]),
    .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(cnt3));

  function automatic int cnt_of(input int idx);
    case (idx)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  // Expected line levels, one per bit period, index 0 = start bit.
  function automatic logic [15:0] frame_model(input logic [8:0] d, input int dbits,
                                              input int par, input int stops);
    logic [15:0] f = '0;
    int n = 1;
    logic p = 1'b0;
    for (int i = 0; i < dbits; i++) begin f[n] = d[i]; p ^= d[i]; n++; end
    if (par == 2)      begin f[n] = p;  n++; end
    else if (par == 1) begin f[n] = ~p; n++; end
    for (int i = 0; i < stops; i++) begin f[n] = 1'b1; n++; end
    return f;
  endfunction

  // Waits for a start bit, then records each bit period's level (x if it moved).
  task automatic capture_frame(input int idx, input int nb, input int max_wait,
                               output int waited, output logic [15:0] bits);
    logic s, lvl;
    bits   = '0;
    waited = 0;
    lvl    = 1'b0;
    @(negedge clk);
    while (tx_w[idx] !== 1'b0 && waited < max_wait) begin @(negedge clk); waited++; end
    if (tx_w[idx] !== 1'b0) begin
      waited = -1;
      bits   = 'x;
      return;
    end
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        s = tx_w[idx];
        if (c == 0) lvl = s;
        else if (s !== lvl) lvl = 1'bx;
      end
      bits[b] = lvl;
    end
  endtask

  task automatic push_word(input int idx, input logic [8:0] d, output bit ok);
    int w = 0;
    s_valid[idx] = 1'b1;
    s_data[idx]  = d;
    while (s_ready_w[idx] !== 1'b1 && w < 500) begin @(negedge clk); w++; end
    ok = (s_ready_w[idx] === 1'b1);
    if (ok) exp_q.push_back(d);
    @(negedge clk);
    s_valid[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (tx_w !== 4'hF) begin n_fail++; $display("FAIL reset_tx: got %b expected 1111", tx_w); end
    n_checks++; if (busy_w !== 4'h0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0000", busy_w); end
    n_checks++; if (s_ready_w !== 4'hF) begin n_fail++; $display("FAIL reset_ready: got %b expected 1111", s_ready_w); end
    n_checks++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", cnt0); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (tx_w !== 4'hF || busy_w !== 4'h0) begin
      n_fail++; $display("FAIL post_reset_idle: tx %b busy %b expected 1111/0000", tx_w, busy_w);
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    int waited;
    logic [15:0] got, exp;
    push_word(0, 9'h0A5, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_push: got not-accepted expected accepted"); end
    n_checks++; if (cnt0 !== 3'd1 || busy_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL single_queued: count %0d busy %b expected 1/1", cnt0, busy_w[0]);
    end
    capture_frame(0, 10, 5, waited, got);
    n_checks++; if (waited !== 0) begin n_fail++; $display("FAIL single_latency: got %0d expected 0", waited); end
    exp = frame_model(exp_q.pop_front(), 8, 0, 1);
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL single_frame: got %b expected %b", got, exp); end
    @(negedge clk);
    n_checks++; if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL single_end: busy %b tx %b expected 0/1", busy_w[0], tx_w[0]);
    end
  endtask

  task automatic test_parity();
    bit ok;
    int waited, idx, par;
    logic [8:0] words [2];
    logic [15:0] got, exp;
    words = '{9'h007, 9'h0C3};
    for (int j = 0; j < 2; j++) begin
      idx = 1 + j;
      par = (j == 0) ? 2 : 1;
      for (int w = 0; w < 2; w++) begin
        push_word(idx, words[w], ok);
        n_checks++; if (cnt_of(idx) != 1) begin
          n_fail++; $display("FAIL parity_count inst%0d: got %0d expected 1", idx, cnt_of(idx));
        end
        capture_frame(idx, 11, 5, waited, got);
        exp = frame_model(exp_q.pop_front(), 8, par, 1);
        n_checks++; if (got !== exp || waited !== 0) begin
          n_fail++; $display("FAIL parity_frame inst%0d word%0d: got %b wait %0d expected %b wait 0", idx, w, got, waited, exp);
        end
        if (w == 0) begin
          n_checks++; if (got[9] !== ((par == 2) ? 1'b1 : 1'b0)) begin
            n_fail++; $display("FAIL parity_bit_07 inst%0d: got %b expected %b", idx, got[9], (par == 2));
          end
        end
        @(negedge clk);
        n_checks++; if (busy_w[idx] !== 1'b0) begin
          n_fail++; $display("FAIL parity_len inst%0d: busy got %b expected 0 after 110 cycles", idx, busy_w[idx]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [6];
    int acc [6];
    int waited [6];
    logic [15:0] got [6];
    logic [15:0] exp;
    logic ready5;
    int i, cyc;
    words  = '{8'h11, 8'h22, 8'hC3, 8'h5A, 8'hFF, 8'h80};
    ready5 = 1'bx;
    for (int k = 0; k < 6; k++) acc[k] = -1;
    fork
      begin
        i = 0;
        cyc = 0;
        s_valid[0] = 1'b1;
        s_data[0]  = {1'b0, words[0]};
        while (i < 6 && cyc < 400) begin
          if (cyc == 5) ready5 = s_ready_w[0];
          if (s_ready_w[0] === 1'b1) begin
            acc[i] = cyc;
            exp_q.push_back({1'b0, words[i]});
            i++;
          end
          @(negedge clk);
          cyc++;
          if (i < 6) s_data[0] = {1'b0, words[i]};
        end
        s_valid[0] = 1'b0;
      end
      begin
        for (int k = 0; k < 6; k++) capture_frame(0, 10, (k == 0) ? 20 : 0, waited[k], got[k]);
      end
    join
    n_checks++; if (ready5 !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready: got %b expected 0", ready5); end
    n_checks++; if (acc[4] != 4) begin n_fail++; $display("FAIL b2b_accept5: got cycle %0d expected 4", acc[4]); end
    n_checks++; if (acc[5] != 102) begin n_fail++; $display("FAIL b2b_accept6: got cycle %0d expected 102", acc[5]); end
    for (int k = 0; k < 6; k++) begin
      exp = (exp_q.size() > 0) ? frame_model(exp_q.pop_front(), 8, 0, 1) : 16'hxxxx;
      n_checks++; if (got[k] !== exp) begin n_fail++; $display("FAIL b2b_frame%0d: got %b expected %b", k, got[k], exp); end
      n_checks++; if (waited[k] != ((k == 0) ? 1 : 0)) begin
        n_fail++; $display("FAIL b2b_gap%0d: got %0d expected %0d", k, waited[k], (k == 0) ? 1 : 0);
      end
    end
    @(negedge clk);
    n_checks++; if (busy_w[0] !== 1'b0 || cnt0 !== 3'd0) begin
      n_fail++; $display("FAIL b2b_drained: busy %b count %0d expected 0/0", busy_w[0], cnt0);
    end
  endtask

  task automatic test_seven_two();
    bit ok;
    int waited;
    logic [15:0] got, exp;
    push_word(3, 9'h055, ok);
    n_checks++; if (cnt3 !== 5'd1) begin n_fail++; $display("FAIL 7n2_count: got %0d expected 1", cnt3); end
    capture_frame(3, 10, 5, waited, got);
    exp = frame_model(exp_q.pop_front(), 7, 0, 2);
    n_checks++; if (got !== exp || waited !== 0) begin
      n_fail++; $display("FAIL 7n2_frame: got %b wait %0d expected %b wait 0", got, waited, exp);
    end
    @(negedge clk);
    n_checks++; if (busy_w[3] !== 1'b0 || tx_w[3] !== 1'b1) begin
      n_fail++; $display("FAIL 7n2_end: busy %b tx %b expected 0/1", busy_w[3], tx_w[3]);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int bad;
    push_word(0, 9'h0F0, ok);
    push_word(0, 9'h012, ok);
    push_word(0, 9'h034, ok);
    repeat (43) @(negedge clk);
    n_checks++; if (tx_w[0] !== 1'b0 || cnt0 !== 3'd2) begin
      n_fail++; $display("FAIL midreset_pre: tx %b count %0d expected 0/2", tx_w[0], cnt0);
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx_w[0] !== 1'b1) begin n_fail++; $display("FAIL midreset_tx: got %b expected 1", tx_w[0]); end
    n_checks++; if (cnt0 !== 3'd0 || busy_w[0] !== 1'b0 || s_ready_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL midreset_state: count %0d busy %b ready %b expected 0/0/1", cnt0, busy_w[0], s_ready_w[0]);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", bad); end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    bit ok, ok2;
    int w1, w2, bad;
    logic [15:0] g1, g2, exp;
    push_word(0, 9'h03C, ok);
    fork
      capture_frame(0, 10, 5, w1, g1);
      begin
        repeat (30) @(negedge clk);
        brk = 1'b1;
        push_word(0, 9'h081, ok2);
      end
    join
    exp = frame_model(exp_q.pop_front(), 8, 0, 1);
    n_checks++; if (g1 !== exp || w1 !== 0) begin
      n_fail++; $display("FAIL break_frame1: got %b wait %0d expected %b wait 0", g1, w1, exp);
    end
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL break_hold: got %0d high cycles expected 0", bad); end
    n_checks++; if (cnt0 !== 3'd1) begin n_fail++; $display("FAIL break_queued: got %0d expected 1", cnt0); end
    brk = 1'b0;
    capture_frame(0, 10, 40, w2, g2);
    n_checks++; if (w2 != 10) begin n_fail++; $display("FAIL break_mark: got %0d high cycles expected 10", w2); end
    exp = frame_model(exp_q.pop_front(), 8, 0, 1);
    n_checks++; if (g2 !== exp) begin n_fail++; $display("FAIL break_frame2: got %b expected %b", g2, exp); end
    @(negedge clk);
    n_checks++; if (busy_w[0] !== 1'b0) begin n_fail++; $display("FAIL break_end: busy got %b expected 0", busy_w[0]); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    s_valid = '0;
    for (int k = 0; k < 4; k++) s_data[k] = '0;
`ifdef UART_TX_BREAK_EN
    brk = 1'b0;
`endif
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_seven_two();
    test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
